eightbyeight_block_serializer: RTL

EIGHTBYEIGHT_BLOCK_SERIALIZER -- requirements
Module: eightbyeight_block_serializer

---
 rtl/eightbyeight_pkg.sv | 19 +
 rtl/eightbyeight_block_serializer_if.sv | 27 ++
 rtl/eightbyeight_block_serializer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/eightbyeight_pkg.sv
// Shared constants and types for the 8x8 block datapath (serializer, SAD).
// Block geometry defaults and serializer state encoding live here.
package eightbyeight_pkg;

  localparam int PIX_W = 8;
  localparam int DIM   = 8;
  localparam int BLK_W = DIM * DIM * PIX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Bit-counter width; a 1-bit block still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eightbyeight_block_serializer_if.sv
// Handshake/serial bundle around eightbyeight_block_serializer.
// master = block producer / serial consumer side, slave = serializer side.
interface eightbyeight_block_serializer_if #(
  parameter int BLK_W = eightbyeight_pkg::BLK_W
);

  logic             in_valid;
  logic [BLK_W-1:0] in_pixels;
  logic             in_ready;
  logic             sout_en;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             sout_last;
  logic [15:0]      blk_cnt;

  modport master (
    output in_valid, in_pixels, sout_en,
    input  in_ready, sout, sout_valid, sout_first, sout_last, blk_cnt
  );

  modport slave (
    input  in_valid, in_pixels, sout_en,
    output in_ready, sout, sout_valid, sout_first, sout_last, blk_cnt
  );

endinterface

// File: rtl/eightbyeight_block_serializer.sv
// Parallel-to-serial converter for one pixel block, MSB first, with a
// one-deep pending buffer so consecutive blocks stream with no gap.
module eightbyeight_block_serializer
  import eightbyeight_pkg::ser_state_e;
  import eightbyeight_pkg::IDLE;
  import eightbyeight_pkg::SHIFT;
  import eightbyeight_pkg::cnt_width;
#(
  parameter  int PIX_W = eightbyeight_pkg::PIX_W,
  parameter  int DIM   = eightbyeight_pkg::DIM,
  localparam int BLK_W = DIM * DIM * PIX_W
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             in_valid,
  input  logic [BLK_W-1:0] in_pixels,
  output logic             in_ready,
  input  logic             sout_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic [15:0]      blk_cnt
);

  localparam int               CNT_W    = cnt_width(BLK_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_W - 1);

  ser_state_e       state_q, state_d;
  logic [BLK_W-1:0] shift_q, shift_d;
  logic [BLK_W-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      blk_cnt_q, blk_cnt_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;

  logic accept;
  logic last_adv;

  // in_ready depends only on a flop, so upstream never sees a loop through us.
  assign in_ready = ~pend_full_q;
  assign accept   = in_valid & ~pend_full_q;
  assign last_adv = (state_q == SHIFT) & sout_en & (cnt_q == CNT_LAST);

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cnt_d       = cnt_q;
    blk_cnt_d   = blk_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = in_pixels;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sout_en) begin
          if (cnt_q == CNT_LAST) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
            cnt_d     = '0;
            if (pend_full_q) begin
              shift_d     = pend_q;
              pend_full_d = 1'b0;
            end else if (accept) begin
              shift_d = in_pixels;
            end else begin
              shift_d = '0;
              state_d = IDLE;
            end
          end else begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        // A block arriving on the final advance went straight to shift_d above.
        if (accept && !last_adv) begin
          pend_d      = in_pixels;
          pend_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == SHIFT);
    sout_d  = valid_d & shift_d[BLK_W-1];
    first_d = valid_d & (cnt_d == '0);
    last_d  = valid_d & (cnt_d == CNT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= IDLE;
      // NOTE: the data registers are wide, but clearing them keeps a
      // discarded block from ever resurfacing and makes sout=0 in reset.
      shift_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
      blk_cnt_q   <= '0;
      sout_q      <= 1'b0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      cnt_q       <= cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      sout_q      <= sout_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign sout_first = first_q;
  assign sout_last  = last_q;
  assign blk_cnt    = blk_cnt_q;

endmodule
